// File: rtl/miriscv_lsu.sv
// -----------------------------------------------------------------------------
// miriscv_lsu -- load/store unit between the core pipeline and a fixed-latency
// data memory.
//
// A request presented in IDLE is checked for alignment. Aligned requests are
// latched and run through ACCESS (one-cycle memory strobe) and WAIT
// (DMEM_LATENCY cycles, the last of which carries the read word). Misaligned
// requests are rejected with a one-cycle lsu_misalign_o pulse and never reach
// memory.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   lsu_req_i        core requests a load/store this cycle
//   lsu_we_i         1 = store, 0 = load
//   lsu_size_i       000 B, 001 H, 010 W, 100 BU, 101 HU (others misaligned)
//   lsu_addr_i       byte address
//   lsu_data_i       store data, right-aligned
//   lsu_data_o       registered load result, sign/zero extended
//   lsu_stall_req_o  core must hold PC and inputs while high
//   lsu_misalign_o   one-cycle pulse: request rejected as misaligned
//   data_req_o       memory access strobe (ACCESS only)
//   data_we_o        memory write enable
//   data_be_o        byte enables
//   data_addr_o      word-aligned address
//   data_wdata_o     store data replicated into byte lanes
//   data_rdata_i     memory read word, valid in the last WAIT cycle
// -----------------------------------------------------------------------------
module miriscv_lsu #(
    parameter int DMEM_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    // WAIT counter runs 0 .. DMEM_LATENCY-1; the final value marks the cycle
    // in which the read word is valid.
    localparam logic [2:0] LAST_WAIT = 3'(DMEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_rdata;

    logic        w_misalign;
    logic        w_accept;
    logic        w_last_wait;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [15:0] w_lane;
    logic [31:0] w_load;

    // Alignment check on the live request; unknown sizes count as misaligned.
    always_comb begin
        w_misalign = 1'b1;
        case (lsu_size_i)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = lsu_addr_i[0];
            3'b010:         w_misalign = |lsu_addr_i[1:0];
            default:        w_misalign = 1'b1;
        endcase
    end

    assign w_accept    = (r_state == ST_IDLE) && lsu_req_i && !w_misalign && !rst_i;
    assign w_last_wait = (r_state == ST_WAIT) && (r_wait_cnt == LAST_WAIT);

    // Byte enables from the latched size and low address bits.
    always_comb begin
        w_be = 4'b1111;
        case (r_size[1:0])
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = 4'b0011 << r_addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    // Store data replicated so every lane carries the bytes it would need.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign w_wdata[8*gi +: 8] =
            (r_size[1:0] == 2'b00) ? r_data[7:0] :
            (r_size[1:0] == 2'b01) ? r_data[8*(gi%2) +: 8] :
                                     r_data[8*gi +: 8];
    end

    // Move the addressed byte/half down to bit 0, then extend.
    assign w_lane = 16'(data_rdata_i >> {r_addr[1:0], 3'b000});

    always_comb begin
        w_load = data_rdata_i;
        case (r_size)
            3'b000:  w_load = {{24{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {24'h0, w_lane[7:0]};
            3'b101:  w_load = {16'h0, w_lane[15:0]};
            default: w_load = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
            r_we       <= 1'b0;
            r_size     <= 3'd0;
            r_addr     <= 32'h0;
            r_data     <= 32'h0;
            r_rdata    <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_ACCESS) begin
                r_wait_cnt <= 3'd0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
            if (w_accept) begin
                r_we   <= lsu_we_i;
                r_size <= lsu_size_i;
                r_addr <= lsu_addr_i;
                r_data <= lsu_data_i;
            end
            // Stores leave the previous load result untouched.
            if (w_last_wait && !r_we) begin
                r_rdata <= w_load;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_ACCESS;
            ST_ACCESS: w_state_next = ST_WAIT;
            ST_WAIT:   if (w_last_wait) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted. Stall drops in the last
    // WAIT cycle so the core can present its next request in the following
    // IDLE cycle.
    always_comb begin
        lsu_stall_req_o = 1'b0;
        lsu_misalign_o  = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'h0;
        data_wdata_o    = 32'h0;
        if (!rst_i) begin
            case (r_state)
                ST_IDLE: begin
                    lsu_stall_req_o = w_accept;
                    lsu_misalign_o  = lsu_req_i && w_misalign;
                end
                ST_ACCESS: begin
                    lsu_stall_req_o = 1'b1;
                    data_req_o      = 1'b1;
                    data_we_o       = r_we;
                    data_be_o       = w_be;
                    data_addr_o     = {r_addr[31:2], 2'b00};
                    data_wdata_o    = w_wdata;
                end
                ST_WAIT: begin
                    lsu_stall_req_o = !w_last_wait;
                end
                default: begin
                    lsu_stall_req_o = 1'b0;
                end
            endcase
        end
    end

    assign lsu_data_o = r_rdata;

endmodule
